fetch_bus_scheduler: RTL

- Shares the single 8-bit memory bus between instruction fetch, pipeline data accesses and an external DMA requester.
- Drives bus_request and fetch_suppress into stage-0 fetch:
  - both 0: stage 0 takes the fetched byte from the bus.
  - both 1: stage 0 replays the previous instruction.
  - mixed: stage 0 emits a NOP (0).
- Sequences each bus steal as fetch -> hold -> recover -> fetch, so no instruction byte is lost or duplicated.
- Arbitrates round-robin between data accesses and DMA.

---
 rtl/control_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/fetch_bus_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the fetch bus scheduler: state/owner codes and arbiter request slots.
package control_pkg;

  // The bus_owner debug port carries this encoding unchanged.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_MEM     = 2'd1,
    ST_DMA     = 2'd2,
    ST_RECOVER = 2'd3
  } owner_e;

  localparam int ARB_MEM = 0;
  localparam int ARB_DMA = 1;

  function automatic logic owner_is_steal(input owner_e st);
    return (st == ST_MEM) || (st == ST_DMA);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. After any grant, the priority bit favours the
// requester that did not win.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // prio_q = 0: requester 0 wins a contest; prio_q = 1: requester 1 wins.
  logic prio_q;

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (en && (|req)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/fetch_bus_scheduler.sv
// Shares the 8-bit memory bus between instruction fetch, data accesses and DMA,
// framing every steal as fetch -> hold -> recover -> fetch.
module fetch_bus_scheduler
  import control_pkg::*;
#(
  parameter int MAX_DMA_BURST = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_req,
  input  logic [1:0] mem_cycles,
  output logic       mem_ack,
  input  logic       dma_req,
  output logic       dma_grant,
  output logic       bus_request,
  output logic       fetch_suppress,
  output logic [1:0] bus_owner
);

  owner_e           state_q, state_n;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_n;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_n;
  logic [1:0]       arb_req, arb_gnt;
  logic             arb_en;

  assign arb_req[ARB_MEM] = mem_req;
  assign arb_req[ARB_DMA] = dma_req;
  assign arb_en           = (state_q == ST_FETCH);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_n     = state_q;
    cyc_cnt_n   = cyc_cnt_q;
    burst_cnt_n = burst_cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (arb_gnt[ARB_MEM]) begin
          state_n   = ST_MEM;
          // A zero cycle count is treated as a single-cycle access.
          cyc_cnt_n = (mem_cycles == 2'd0) ? '0 : (CNT_W'(mem_cycles) - CNT_W'(1));
        end else if (arb_gnt[ARB_DMA]) begin
          state_n     = ST_DMA;
          burst_cnt_n = CNT_W'(MAX_DMA_BURST - 1);
        end
      end
      ST_MEM: begin
        if (cyc_cnt_q == '0) begin
          state_n = ST_RECOVER;
        end else begin
          cyc_cnt_n = cyc_cnt_q - CNT_W'(1);
        end
      end
      ST_DMA: begin
        if (!dma_req || (burst_cnt_q == '0)) begin
          state_n = ST_RECOVER;
        end else begin
          burst_cnt_n = burst_cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        state_n = ST_FETCH;
      end
      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      cyc_cnt_q      <= '0;
      burst_cnt_q    <= '0;
      mem_ack        <= 1'b0;
      dma_grant      <= 1'b0;
      bus_request    <= 1'b0;
      fetch_suppress <= 1'b0;
      bus_owner      <= 2'd0;
    end else begin
      state_q        <= state_n;
      cyc_cnt_q      <= cyc_cnt_n;
      burst_cnt_q    <= burst_cnt_n;
      mem_ack        <= (state_n == ST_MEM) && (cyc_cnt_n == '0);
      dma_grant      <= (state_n == ST_DMA);
      bus_request    <= owner_is_steal(state_n);
      fetch_suppress <= (state_n != ST_FETCH);
      bus_owner      <= state_n;
    end
  end

endmodule
